// File: rtl/t_to_sr_ff_bank.sv
// t_to_sr_ff_bank: T flip-flop bank excited as SR/JK/D/T, with illegal-SR hold FSM and toggle counter.
module t_to_sr_ff_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] t_exc,
    output logic             illegal,
    output logic             err_sticky,
    output logic             hold,
    output logic [CNT_W-1:0] toggle_cnt
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               illegal_q, illegal_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_jk, t_raw;
    logic               run, ill_ev;
    logic [CNT_W:0]     pop, sum;

    always_comb begin
        run    = state_q == RUN;
        sr_jk  = (a & ~q_q) | (b & q_q);
        // SR masks a=b=1 bits to no-change; JK lets them toggle
        t_raw  = mode == 2'b00 ? sr_jk & ~(a & b) :
                 mode == 2'b01 ? sr_jk :
                 mode == 2'b10 ? a ^ q_q : a;
        t_exc  = (en && run) ? t_raw : '0;
        ill_ev = en && run && mode == 2'b00 && |(a & b);
        q_d    = q_q ^ t_exc;
        pop    = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (CNT_W+1)'(t_exc[i]);
        sum    = {1'b0, cnt_q} + pop;
        cnt_d  = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = ill_ev;
        err_d     = ill_ev ? 1'b1 : clr_err ? 1'b0 : err_q;
        if (run && ill_ev) state_d = HOLD;
        else if (!run && clr_err) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            q_q       <= '0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q          = q_q;
    assign q_bar      = ~q_q;
    assign illegal    = illegal_q;
    assign err_sticky = err_q;
    assign hold       = state_q == HOLD;
    assign toggle_cnt = cnt_q;
endmodule

// File: tb/tb_t_to_sr_ff_bank.sv
// tb_t_to_sr_ff_bank: directed vectors feed a scoreboard queue; a negedge monitor pops and compares.
module tb_t_to_sr_ff_bank;
    localparam int SQ = 0, SQB = 1, STX = 2, SILL = 3, SERR = 4, SHOLD = 5, SCNT = 6, SCNT4 = 7;

    typedef struct {
        string       nm;
        int          sig;
        logic [31:0] v;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  a = '0, b = '0;
    logic        clr_err = 1'b0;
    logic [3:0]  q, q_bar, t_exc, q4, q_bar4, t_exc4;
    logic        illegal, err_sticky, hold, illegal4, err4, hold4;
    logic [15:0] toggle_cnt;
    logic [3:0]  cnt4;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    t_to_sr_ff_bank dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q), .q_bar(q_bar), .t_exc(t_exc), .illegal(illegal), .err_sticky(err_sticky),
        .hold(hold), .toggle_cnt(toggle_cnt)
    );

    t_to_sr_ff_bank #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q4), .q_bar(q_bar4), .t_exc(t_exc4), .illegal(illegal4), .err_sticky(err4),
        .hold(hold4), .toggle_cnt(cnt4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(int s);
        case (s)
            SQ:      return 32'(q);
            SQB:     return 32'(q_bar);
            STX:     return 32'(t_exc);
            SILL:    return 32'(illegal);
            SERR:    return 32'(err_sticky);
            SHOLD:   return 32'(hold);
            SCNT:    return 32'(toggle_cnt);
            default: return 32'(cnt4);
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (act(e.sig) !== e.v) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got %0h, expected %0h", e.nm, cyc, act(e.sig), e.v);
            end
        end
    end

    task automatic expect_(string nm, int sig, logic [31:0] v, int dly);
        sb.push_back('{nm, sig, v, cyc + dly});
    endtask

    task automatic drv(bit e_, bit [1:0] m, bit [3:0] aa, bit [3:0] bb, bit c);
        @(posedge clk);
        #2;
        en = e_; mode = m; a = aa; b = bb; clr_err = c;
    endtask

    task automatic do_reset(string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; a = '0; b = '0; clr_err = 1'b0;
        expect_({tag, "_q"}, SQ, 32'h0, 0);
        expect_({tag, "_qbar"}, SQB, 32'hF, 0);
        expect_({tag, "_ill"}, SILL, 32'h0, 0);
        expect_({tag, "_err"}, SERR, 32'h0, 0);
        expect_({tag, "_hold"}, SHOLD, 32'h0, 0);
        expect_({tag, "_cnt"}, SCNT, 32'h0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset("rst0");
        // T mode toggling and counter saturation on the narrow-counter instance
        drv(1, 2'b11, 4'hF, 4'h0, 0); expect_("t_tx1", STX, 32'hF, 0); expect_("t_q1", SQ, 32'hF, 1);
        drv(1, 2'b11, 4'hF, 4'h0, 0); expect_("t_q2", SQ, 32'h0, 1);
        drv(1, 2'b11, 4'hF, 4'h0, 0); expect_("t_q3", SQ, 32'hF, 1);
        drv(0, 2'b11, 4'hF, 4'h0, 0); expect_("t_cnt12", SCNT, 32'd12, 0); expect_("t_cnt4_12", SCNT4, 32'd12, 0);
        expect_("t_en0_tx", STX, 32'h0, 0);
        drv(1, 2'b11, 4'hF, 4'h0, 0);
        drv(1, 2'b11, 4'hF, 4'h0, 0); expect_("sat_cnt4_a", SCNT4, 32'd15, 0); expect_("cnt16", SCNT, 32'd16, 0);
        drv(0, 2'b11, 4'hF, 4'h0, 0); expect_("sat_cnt4_b", SCNT4, 32'd15, 0); expect_("cnt20", SCNT, 32'd20, 0);
        expect_("t_q5", SQ, 32'hF, 0);

        do_reset("rst1");
        drv(1, 2'b00, 4'h3, 4'h0, 0); expect_("sr_tx3", STX, 32'h3, 0); expect_("sr_q3", SQ, 32'h3, 1);
        drv(1, 2'b00, 4'h0, 4'h1, 0); expect_("sr_tx1", STX, 32'h1, 0); expect_("sr_q2", SQ, 32'h2, 1);
        drv(1, 2'b00, 4'hC, 4'h4, 0); expect_("sr11_tx", STX, 32'h8, 0); expect_("sr11_q", SQ, 32'hA, 1);
        expect_("sr11_ill", SILL, 32'h1, 1); expect_("sr11_err", SERR, 32'h1, 1); expect_("sr11_hold", SHOLD, 32'h1, 1);
        drv(1, 2'b10, 4'hF, 4'h0, 0); expect_("hold_tx", STX, 32'h0, 0); expect_("hold_qbar", SQB, 32'h5, 0);
        expect_("ill_pulse_end", SILL, 32'h0, 1); expect_("hold_q", SQ, 32'hA, 1);
        drv(1, 2'b00, 4'hF, 4'hF, 0); expect_("hold_sr11_tx", STX, 32'h0, 0);
        expect_("hold_no_ill", SILL, 32'h0, 1); expect_("hold_q2", SQ, 32'hA, 1);
        drv(1, 2'b10, 4'hF, 4'h0, 1); expect_("clr_tx", STX, 32'h0, 0);
        expect_("clr_hold", SHOLD, 32'h0, 1); expect_("clr_err", SERR, 32'h0, 1); expect_("clr_q", SQ, 32'hA, 1);
        drv(1, 2'b10, 4'hF, 4'h0, 0); expect_("d_tx", STX, 32'h5, 0); expect_("d_q", SQ, 32'hF, 1);
        // clr_err in RUN loses to a simultaneous illegal event
        drv(1, 2'b00, 4'h2, 4'h7, 1); expect_("win_tx", STX, 32'h5, 0); expect_("win_q", SQ, 32'hA, 1);
        expect_("win_hold", SHOLD, 32'h1, 1); expect_("win_err", SERR, 32'h1, 1); expect_("win_ill", SILL, 32'h1, 1);
        drv(0, 2'b00, 4'h0, 4'h0, 0);
        do_reset("async");

        drv(1, 2'b10, 4'h5, 4'h0, 0); expect_("jk_pre_q", SQ, 32'h5, 1);
        drv(1, 2'b01, 4'hF, 4'hF, 0); expect_("jk_tx", STX, 32'hF, 0); expect_("jk_qA", SQ, 32'hA, 1);
        expect_("jk_no_ill", SILL, 32'h0, 1); expect_("jk_no_hold", SHOLD, 32'h0, 1);
        drv(1, 2'b01, 4'h0, 4'hF, 0); expect_("jk_k_tx", STX, 32'hA, 0); expect_("jk_q0", SQ, 32'h0, 1);
        drv(0, 2'b01, 4'hF, 4'h0, 0); expect_("jk_en0_tx", STX, 32'h0, 0); expect_("jk_en0_q", SQ, 32'h0, 1);
        drv(0, 2'b00, 4'hF, 4'hF, 0); expect_("en0_sr11_ill", SILL, 32'h0, 1); expect_("en0_sr11_hold", SHOLD, 32'h0, 1);
        drv(0, 2'b00, 4'h0, 4'h0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
